cva5_flush_fifo: RTL and testbench

//  Parametrised successor to the core's small-FIFO primitive. Supports any DEPTH (not only powers of 2).

---
 rtl/cva5_flush_fifo.sv | 143 ++++++++++++++
 tb/tb_cva5_flush_fifo.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cva5_flush_fifo.sv
// -----------------------------------------------------------------------------
// cva5_flush_fifo
//   First-word-fall-through FIFO for use between pipeline stages that can be
//   squashed. Any DEPTH >= 2 is supported because the pointers wrap by an
//   explicit compare against DEPTH-1. It provides an occupancy count, an
//   almost-full threshold, a single-cycle flush, an optional empty-bypass
//   path, and sticky overflow/underflow flags. A push into a full FIFO, or a
//   pop from an empty one, is dropped and recorded in those flags.
//
// Parameters
//   DATA_WIDTH : width of data_in / data_out
//   DEPTH      : number of entries (>= 2, any integer)
//   AF_THRESH  : almost_full asserted when count >= AF_THRESH (1..DEPTH)
//   BYPASS     : 1 = when empty, a push appears on data_out in the same cycle
//   ASSERT_ON  : 1 = enable the simulation-only misuse assertions
//
// Ports
//   clk         in  clock
//   rst         in  synchronous active-high reset
//   flush       in  discard all contents (priority below rst)
//   push        in  enqueue data_in
//   data_in     in  write data
//   pop         in  dequeue head entry
//   data_out    out head entry (don't-care while valid = 0)
//   valid       out data_out holds an entry
//   full        out count == DEPTH
//   almost_full out count >= AF_THRESH
//   count       out occupancy, 0..DEPTH
//   overflow    out sticky: a push was dropped while full
//   underflow   out sticky: a pop was issued while empty
//
// Handshake: the consumer side is valid/pop. The head entry is transferred on
//   any clock edge where valid & pop, and pop has no effect while valid = 0.
//   The producer side is push with full as the inverse of ready. An entry is
//   transferred on any edge where push & (~full | pop), so a push into a full
//   FIFO is accepted only when a pop frees the head slot in the same cycle.
//   Nothing is transferred on an edge where flush or rst is high.
// -----------------------------------------------------------------------------
module cva5_flush_fifo #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 4,
   parameter int AF_THRESH  = 3,
   parameter int BYPASS     = 0,
   parameter int ASSERT_ON  = 1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         flush,
   input  logic                         push,
   input  logic [DATA_WIDTH-1:0]        data_in,
   input  logic                         pop,
   output logic [DATA_WIDTH-1:0]        data_out,
   output logic                         valid,
   output logic                         full,
   output logic                         almost_full,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         overflow,
   output logic                         underflow
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = $clog2(DEPTH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]         rd_ptr;
   logic [PW-1:0]         wr_ptr;
   logic [CW-1:0]         count_r;

   logic empty;
   logic bypass_empty;
   logic push_ok;
   logic pop_ok;
   logic pass_through;
   logic wr_en;
   logic rd_en;

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      // Explicit wrap so that non-power-of-2 depths work.
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign empty        = (count_r == '0);
   assign full         = (count_r == CW'(DEPTH));
   assign almost_full  = (count_r >= CW'(AF_THRESH));
   assign count        = count_r;
   assign bypass_empty = (BYPASS != 0) && empty;

   // While empty in bypass mode, the incoming word is presented directly.
   assign valid    = bypass_empty ? push    : !empty;
   assign data_out = bypass_empty ? data_in : mem[rd_ptr];

   assign push_ok = push & (~full | pop);
   assign pop_ok  = pop & valid;

   // If a bypassed word is consumed in the same cycle it never touches
   // storage, so neither pointer moves.
   assign pass_through = bypass_empty & push & pop;
   assign wr_en        = push_ok & ~pass_through;
   assign rd_en        = pop_ok  & ~pass_through;

   // Storage is intentionally not reset.
   always_ff @(posedge clk) begin
      if (!rst && !flush && wr_en) begin
         mem[wr_ptr] <= data_in;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_r   <= '0;
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else if (flush) begin
         // Flags are kept through a flush and are cleared only by rst.
         count_r <= '0;
         rd_ptr  <= '0;
         wr_ptr  <= '0;
      end else begin
         if (wr_en) wr_ptr <= next_ptr(wr_ptr);
         if (rd_en) rd_ptr <= next_ptr(rd_ptr);
         case ({wr_en, rd_en})
            2'b10:   count_r <= count_r + CW'(1);
            2'b01:   count_r <= count_r - CW'(1);
            default: count_r <= count_r;
         endcase
         if (push && full && !pop) overflow  <= 1'b1;
         if (pop && !valid)        underflow <= 1'b1;
      end
   end

`ifndef SYNTHESIS
   a_no_push_when_full : assert property (@(posedge clk)
      disable iff (rst || (ASSERT_ON == 0)) !(push && full && !pop))
      else $error("cva5_flush_fifo: push while full without pop");

   a_no_pop_when_empty : assert property (@(posedge clk)
      disable iff (rst || (ASSERT_ON == 0)) !(pop && !valid))
      else $error("cva5_flush_fifo: pop while not valid");
`endif

endmodule

// File: tb/tb_cva5_flush_fifo.sv
// -----------------------------------------------------------------------------
// tb_cva5_flush_fifo
//   Three FIFO instances share one stimulus stream:
//     k=0 : DEPTH=5, AF_THRESH=3, BYPASS=0
//     k=1 : DEPTH=4, AF_THRESH=3, BYPASS=0
//     k=2 : DEPTH=4, AF_THRESH=2, BYPASS=1
//   A queue-based reference model predicts each instance's outputs every cycle.
//   Directed tables and sequences add explicit constant expectations.
// -----------------------------------------------------------------------------
module tb_cva5_flush_fifo;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst   = 1'b1;
   logic        flush = 1'b0;
   logic        push  = 1'b0;
   logic        pop   = 1'b0;
   logic [15:0] din   = '0;

   logic [2:0][15:0] dout;
   logic [2:0][2:0]  cnt;
   logic [2:0]       vld, ful, af, ovf, udf;

   cva5_flush_fifo #(.DATA_WIDTH(16), .DEPTH(5), .AF_THRESH(3), .BYPASS(0), .ASSERT_ON(0)) u_a (
      .clk(clk), .rst(rst), .flush(flush), .push(push), .data_in(din), .pop(pop),
      .data_out(dout[0]), .valid(vld[0]), .full(ful[0]), .almost_full(af[0]),
      .count(cnt[0]), .overflow(ovf[0]), .underflow(udf[0]));

   cva5_flush_fifo #(.DATA_WIDTH(16), .DEPTH(4), .AF_THRESH(3), .BYPASS(0), .ASSERT_ON(0)) u_b (
      .clk(clk), .rst(rst), .flush(flush), .push(push), .data_in(din), .pop(pop),
      .data_out(dout[1]), .valid(vld[1]), .full(ful[1]), .almost_full(af[1]),
      .count(cnt[1]), .overflow(ovf[1]), .underflow(udf[1]));

   cva5_flush_fifo #(.DATA_WIDTH(16), .DEPTH(4), .AF_THRESH(2), .BYPASS(1), .ASSERT_ON(0)) u_c (
      .clk(clk), .rst(rst), .flush(flush), .push(push), .data_in(din), .pop(pop),
      .data_out(dout[2]), .valid(vld[2]), .full(ful[2]), .almost_full(af[2]),
      .count(cnt[2]), .overflow(ovf[2]), .underflow(udf[2]));

   // ---------------- reference model ----------------
   int          depth_k [3] = '{5, 4, 4};
   int          af_k    [3] = '{3, 3, 2};
   bit          byp_k   [3] = '{1'b0, 1'b0, 1'b1};
   logic [15:0] q0 [$];
   logic [15:0] q1 [$];
   logic [15:0] q2 [$];
   bit          m_ovf [3];
   bit          m_udf [3];
   bit          m_known = 1'b0;

   int checks   = 0;
   int failures = 0;

   function automatic int msize(input int k);
      case (k)
         0:       return q0.size();
         1:       return q1.size();
         default: return q2.size();
      endcase
   endfunction

   function automatic logic [15:0] mhead(input int k);
      if (msize(k) == 0) return 16'h0;
      case (k)
         0:       return q0[0];
         1:       return q1[0];
         default: return q2[0];
      endcase
   endfunction

   task automatic mpush(input int k, input logic [15:0] d);
      case (k)
         0:       q0.push_back(d);
         1:       q1.push_back(d);
         default: q2.push_back(d);
      endcase
   endtask

   task automatic mpop(input int k);
      logic [15:0] t;
      case (k)
         0:       t = q0.pop_front();
         1:       t = q1.pop_front();
         default: t = q2.pop_front();
      endcase
   endtask

   task automatic mclear(input int k);
      case (k)
         0:       q0.delete();
         1:       q1.delete();
         default: q2.delete();
      endcase
   endtask

   task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s[inst%0d] t=%0t got=%0h expected=%0h", name, k, $time, act, exp);
      end
   endtask

   // Compare one instance against the model's prediction for the current cycle.
   task automatic check_inst(input int k);
      int   c;
      bit   bp;
      logic ev;
      logic [15:0] ed;
      c  = msize(k);
      bp = byp_k[k] && (c == 0);
      ev = bp ? push : (c != 0);
      ed = bp ? din : mhead(k);
      check("m_count", k, 32'(cnt[k]), 32'(c));
      check("m_valid", k, 32'(vld[k]), 32'(ev));
      if (ev) check("m_data", k, 32'(dout[k]), 32'(ed));
      check("m_full",  k, 32'(ful[k]), 32'(c == depth_k[k]));
      check("m_afull", k, 32'(af[k]),  32'(c >= af_k[k]));
      check("m_ovf",   k, 32'(ovf[k]), 32'(m_ovf[k]));
      check("m_udf",   k, 32'(udf[k]), 32'(m_udf[k]));
   endtask

   // Apply the spec rules to the model for the clock edge that is about to occur.
   task automatic model_update();
      int c;
      bit is_full, is_valid;
      if (rst) begin
         for (int k = 0; k < 3; k++) begin
            mclear(k);
            m_ovf[k] = 1'b0;
            m_udf[k] = 1'b0;
         end
         m_known = 1'b1;
      end else begin
         for (int k = 0; k < 3; k++) begin
            if (flush) begin
               mclear(k);
            end else begin
               c        = msize(k);
               is_full  = (c == depth_k[k]);
               is_valid = (byp_k[k] && c == 0) ? push : (c != 0);
               if (push && is_full && !pop) m_ovf[k] = 1'b1;
               if (pop && !is_valid)        m_udf[k] = 1'b1;
               if (!(byp_k[k] && c == 0 && push && pop)) begin
                  if (pop && is_valid)              mpop(k);
                  if (push && (!is_full || pop))    mpush(k, din);
               end
            end
         end
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic drive(input bit r, input bit f, input bit pu, input bit po, input logic [15:0] d);
      rst = r; flush = f; push = pu; pop = po; din = d;
      @(negedge clk);
   endtask

   task automatic finish_cycle();
      if (m_known) for (int k = 0; k < 3; k++) check_inst(k);
      model_update();
      @(posedge clk);
      #1;
   endtask

   task automatic cyc(input bit r, input bit f, input bit pu, input bit po, input logic [15:0] d);
      drive(r, f, pu, po, d);
      finish_cycle();
   endtask

   // ---------------- directed table ----------------
   typedef struct {
      logic        push;
      logic        pop;
      logic [15:0] din;
      int          e_cnt;
      logic        e_vld;
      logic        e_full;
      logic        e_af;
      logic [15:0] e_dout;
   } vec_t;

   vec_t t1 [11];
   logic [15:0] exp_q [$];

   initial begin
      t1[0]  = '{1'b1, 1'b0, 16'h11, 0, 1'b0, 1'b0, 1'b0, 16'h00};
      t1[1]  = '{1'b1, 1'b0, 16'h22, 1, 1'b1, 1'b0, 1'b0, 16'h11};
      t1[2]  = '{1'b1, 1'b0, 16'h33, 2, 1'b1, 1'b0, 1'b0, 16'h11};
      t1[3]  = '{1'b1, 1'b0, 16'h44, 3, 1'b1, 1'b0, 1'b1, 16'h11};
      t1[4]  = '{1'b1, 1'b0, 16'h55, 4, 1'b1, 1'b0, 1'b1, 16'h11};
      t1[5]  = '{1'b0, 1'b1, 16'h00, 5, 1'b1, 1'b1, 1'b1, 16'h11};
      t1[6]  = '{1'b0, 1'b1, 16'h00, 4, 1'b1, 1'b0, 1'b1, 16'h22};
      t1[7]  = '{1'b0, 1'b1, 16'h00, 3, 1'b1, 1'b0, 1'b1, 16'h33};
      t1[8]  = '{1'b0, 1'b1, 16'h00, 2, 1'b1, 1'b0, 1'b0, 16'h44};
      t1[9]  = '{1'b0, 1'b1, 16'h00, 1, 1'b1, 1'b0, 1'b0, 16'h55};
      t1[10] = '{1'b0, 1'b0, 16'h00, 0, 1'b0, 1'b0, 1'b0, 16'h00};

      @(posedge clk); #1;
      cyc(1, 0, 0, 0, 0);

      // reset state
      drive(0, 0, 0, 0, 0);
      for (int k = 0; k < 3; k++) begin
         check("rst_count", k, 32'(cnt[k]), 32'd0);
         check("rst_valid", k, 32'(vld[k]), 32'd0);
         check("rst_full",  k, 32'(ful[k]), 32'd0);
         check("rst_afull", k, 32'(af[k]),  32'd0);
         check("rst_flags", k, 32'({ovf[k], udf[k]}), 32'd0);
      end
      finish_cycle();

      // 1: fill DEPTH=5 and drain in order
      for (int i = 0; i < 11; i++) begin
         drive(0, 0, t1[i].push, t1[i].pop, t1[i].din);
         check("t1_count", 0, 32'(cnt[0]), 32'(t1[i].e_cnt));
         check("t1_valid", 0, 32'(vld[0]), 32'(t1[i].e_vld));
         check("t1_full",  0, 32'(ful[0]), 32'(t1[i].e_full));
         check("t1_afull", 0, 32'(af[0]),  32'(t1[i].e_af));
         if (t1[i].e_vld) check("t1_data", 0, 32'(dout[0]), 32'(t1[i].e_dout));
         finish_cycle();
      end

      // 2: hold count at 3 with 12 push+pop cycles, wrapping the pointers
      cyc(1, 0, 0, 0, 0);
      exp_q.delete();
      for (int i = 0; i < 3; i++) begin
         cyc(0, 0, 1, 0, 16'h200 + 16'(i));
         exp_q.push_back(16'h200 + 16'(i));
      end
      for (int i = 0; i < 12; i++) begin
         drive(0, 0, 1, 1, 16'h100 + 16'(i));
         exp_q.push_back(16'h100 + 16'(i));
         check("t2_count", 0, 32'(cnt[0]), 32'd3);
         check("t2_data",  0, 32'(dout[0]), 32'(exp_q.pop_front()));
         finish_cycle();
      end
      for (int i = 0; i < 3; i++) begin
         drive(0, 0, 0, 1, 0);
         check("t2_drain", 0, 32'(dout[0]), 32'(exp_q.pop_front()));
         finish_cycle();
      end

      // 3: DEPTH=4 full, push+pop, then overflow
      cyc(1, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0, 16'hA1 + 16'(i));
      drive(0, 0, 1, 1, 16'hAA);
      check("t3_full",  1, 32'(ful[1]), 32'd1);
      check("t3_count", 1, 32'(cnt[1]), 32'd4);
      check("t3_head",  1, 32'(dout[1]), 32'hA1);
      finish_cycle();
      drive(0, 0, 1, 0, 16'hEE);
      check("t3_count2", 1, 32'(cnt[1]), 32'd4);
      check("t3_head2",  1, 32'(dout[1]), 32'hA2);
      finish_cycle();
      exp_q.delete();
      exp_q.push_back(16'hA2); exp_q.push_back(16'hA3);
      exp_q.push_back(16'hA4); exp_q.push_back(16'hAA);
      for (int i = 0; i < 4; i++) begin
         drive(0, 0, 0, 1, 0);
         if (i == 0) begin
            check("t3_ovf",    1, 32'(ovf[1]), 32'd1);
            check("t3_count3", 1, 32'(cnt[1]), 32'd4);
         end
         check("t3_pop", 1, 32'(dout[1]), 32'(exp_q.pop_front()));
         finish_cycle();
      end

      // 4: flush with a simultaneous push
      cyc(1, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 16'h31 + 16'(i));
      drive(0, 1, 1, 0, 16'hBB);
      check("t4_pre", 0, 32'(cnt[0]), 32'd3);
      finish_cycle();
      drive(0, 0, 1, 0, 16'hCC);
      check("t4_count", 0, 32'(cnt[0]), 32'd0);
      check("t4_valid", 0, 32'(vld[0]), 32'd0);
      finish_cycle();
      drive(0, 0, 0, 1, 0);
      check("t4_head", 0, 32'(dout[0]), 32'hCC);
      check("t4_cnt1", 0, 32'(cnt[0]), 32'd1);
      finish_cycle();
      drive(0, 0, 0, 0, 0);
      check("t4_empty", 0, 32'(vld[0]), 32'd0);
      finish_cycle();

      // 5: bypass pass-through, then underflow
      cyc(1, 0, 0, 0, 0);
      drive(0, 0, 1, 1, 16'h5A);
      check("t5_valid", 2, 32'(vld[2]), 32'd1);
      check("t5_data",  2, 32'(dout[2]), 32'h5A);
      check("t5_count", 2, 32'(cnt[2]), 32'd0);
      finish_cycle();
      drive(0, 0, 0, 0, 0);
      check("t5_count2", 2, 32'(cnt[2]), 32'd0);
      check("t5_udf0",   2, 32'(udf[2]), 32'd0);
      finish_cycle();
      cyc(0, 0, 0, 1, 0);
      drive(0, 0, 0, 0, 0);
      check("t5_udf1", 2, 32'(udf[2]), 32'd1);
      finish_cycle();

      // 6: flags survive flush, rst clears them mid-stream
      cyc(1, 0, 0, 0, 0);
      for (int i = 0; i < 6; i++) cyc(0, 0, 1, 0, 16'h61 + 16'(i));
      cyc(0, 1, 0, 0, 0);
      drive(0, 0, 1, 0, 16'h71);
      check("t6_flush_ovf", 0, 32'(ovf[0]), 32'd1);
      check("t6_flush_cnt", 0, 32'(cnt[0]), 32'd0);
      finish_cycle();
      cyc(0, 0, 1, 0, 16'h72);
      drive(1, 0, 0, 0, 0);
      check("t6_pre_cnt", 0, 32'(cnt[0]), 32'd2);
      check("t6_pre_ovf", 0, 32'(ovf[0]), 32'd1);
      finish_cycle();
      drive(0, 0, 0, 0, 0);
      check("t6_cnt",   0, 32'(cnt[0]), 32'd0);
      check("t6_valid", 0, 32'(vld[0]), 32'd0);
      check("t6_ovf",   0, 32'(ovf[0]), 32'd0);
      check("t6_udf",   0, 32'(udf[0]), 32'd0);
      finish_cycle();

      // randomized traffic against the model
      for (int i = 0; i < 800; i++) begin
         cyc($urandom_range(0, 149) == 0,
             $urandom_range(0, 99) < 4,
             $urandom_range(0, 99) < 60,
             $urandom_range(0, 99) < 50,
             16'($urandom_range(0, 65535)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
